// File: rtl/icache_assoc_mem_if.sv
// Fetch/fill/flush bus for the set-associative instruction-cache storage.
// The master side drives requests; the slave side (the cache) returns results.
interface icache_assoc_mem_if #(
  parameter int WAYS     = 4,
  parameter int SETS     = 16,
  parameter int TAG_W    = 8,
  parameter int LINE_W   = 64,
  parameter int RD_PORTS = 2
) ();
  localparam int SET_W  = $clog2(SETS);
  localparam int ADDR_W = TAG_W + SET_W;
  localparam int WAY_W  = $clog2(WAYS);

  logic [RD_PORTS-1:0]        rd_en;
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS-1:0]        rd_touch;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [LINE_W-1:0]          wr_data;
  logic                       wr_ready;
  logic                       flush_req;
  logic [RD_PORTS-1:0]        rd_hit;
  logic [RD_PORTS*LINE_W-1:0] rd_data;
  logic [RD_PORTS*WAY_W-1:0]  rd_way;
  logic                       flush_busy;
  logic                       flush_done;

  modport master (
    output rd_en, rd_addr, rd_touch, wr_en, wr_addr, wr_data, flush_req,
    input  wr_ready, rd_hit, rd_data, rd_way, flush_busy, flush_done
  );

  modport slave (
    input  rd_en, rd_addr, rd_touch, wr_en, wr_addr, wr_data, flush_req,
    output wr_ready, rd_hit, rd_data, rd_way, flush_busy, flush_done
  );
endinterface

// File: rtl/icache_assoc_mem.sv
// N-way set-associative instruction-cache storage with true-LRU replacement,
// multiple registered read ports, one fill port and a set-walking flush engine.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | normal operation: reads hit, fills accepted, LRU touched
// S_FLUSH | walking sets 0..SETS-1, clearing valids and resetting ages
module icache_assoc_mem #(
  parameter int WAYS     = 4,
  parameter int SETS     = 16,
  parameter int TAG_W    = 8,
  parameter int LINE_W   = 64,
  parameter int RD_PORTS = 2
) (
  input  logic                clock,
  input  logic                reset,
  icache_assoc_mem_if.slave   bus
);
  localparam int SET_W  = $clog2(SETS);
  localparam int ADDR_W = TAG_W + SET_W;
  localparam int WAY_W  = $clog2(WAYS);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               flush_done_q, flush_done_d;

  logic               valid_q [SETS][WAYS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]  data_q  [SETS][WAYS];
  logic [WAY_W-1:0]   age_q   [SETS][WAYS];
  logic [WAY_W-1:0]   age_d   [SETS][WAYS];

  logic [SET_W-1:0]   rd_set [RD_PORTS];
  logic [TAG_W-1:0]   rd_tag [RD_PORTS];
  logic               lk_hit [RD_PORTS];
  logic [WAY_W-1:0]   lk_way [RD_PORTS];

  logic [RD_PORTS-1:0]        rd_hit_q;
  logic [RD_PORTS*LINE_W-1:0] rd_data_q;
  logic [RD_PORTS*WAY_W-1:0]  rd_way_q;

  logic [SET_W-1:0]   wr_set;
  logic [TAG_W-1:0]   wr_tag;
  logic               fill;
  logic [WAY_W-1:0]   victim;
  logic [WAY_W-1:0]   vic_tag_way, vic_inv_way, vic_old_way;
  logic               vic_tag_f, vic_inv_f;
  logic [WAY_W-1:0]   touch_age;

  assign wr_set = bus.wr_addr[SET_W-1:0];
  assign wr_tag = bus.wr_addr[ADDR_W-1:SET_W];
  assign fill   = bus.wr_en && (state_q == S_IDLE);

  assign bus.wr_ready   = (state_q == S_IDLE);
  assign bus.flush_busy = (state_q == S_FLUSH);
  assign bus.flush_done = flush_done_q;
  assign bus.rd_hit     = rd_hit_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_way     = rd_way_q;

  // Tag lookup per read port on pre-update state; nothing hits during a flush.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_set[p] = bus.rd_addr[p*ADDR_W +: SET_W];
      rd_tag[p] = bus.rd_addr[p*ADDR_W+SET_W +: TAG_W];
      lk_hit[p] = 1'b0;
      lk_way[p] = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[rd_set[p]][w] && (tag_q[rd_set[p]][w] == rd_tag[p])) begin
          lk_hit[p] = 1'b1;
          lk_way[p] = WAY_W'(w);
        end
      end
      lk_hit[p] = lk_hit[p] && bus.rd_en[p] && (state_q == S_IDLE);
    end
  end

  // Sequential LRU update: read touches in port order, then victim pick and fill touch,
  // then the flush set reset.
  always_comb begin
    age_d       = age_q;
    touch_age   = '0;
    vic_tag_f   = 1'b0;
    vic_inv_f   = 1'b0;
    vic_tag_way = '0;
    vic_inv_way = '0;
    vic_old_way = '0;
    victim      = '0;

    for (int p = 0; p < RD_PORTS; p++) begin
      if (lk_hit[p] && bus.rd_touch[p]) begin
        touch_age = age_d[rd_set[p]][lk_way[p]];
        for (int w = 0; w < WAYS; w++) begin
          if (age_d[rd_set[p]][w] < touch_age)
            age_d[rd_set[p]][w] = age_d[rd_set[p]][w] + WAY_W'(1);
        end
        age_d[rd_set[p]][lk_way[p]] = '0;
      end
    end

    for (int w = 0; w < WAYS; w++) begin
      if (!vic_tag_f && valid_q[wr_set][w] && (tag_q[wr_set][w] == wr_tag)) begin
        vic_tag_f   = 1'b1;
        vic_tag_way = WAY_W'(w);
      end
      if (!vic_inv_f && !valid_q[wr_set][w]) begin
        vic_inv_f   = 1'b1;
        vic_inv_way = WAY_W'(w);
      end
      if (age_d[wr_set][w] == WAY_W'(WAYS-1))
        vic_old_way = WAY_W'(w);
    end
    victim = vic_tag_f ? vic_tag_way : (vic_inv_f ? vic_inv_way : vic_old_way);

    if (fill) begin
      touch_age = age_d[wr_set][victim];
      for (int w = 0; w < WAYS; w++) begin
        if (age_d[wr_set][w] < touch_age)
          age_d[wr_set][w] = age_d[wr_set][w] + WAY_W'(1);
      end
      age_d[wr_set][victim] = '0;
    end

    if (state_q == S_FLUSH) begin
      for (int w = 0; w < WAYS; w++)
        age_d[flush_cnt_q][w] = WAY_W'(w);
    end
  end

  // Flush walk next-state: one set per cycle, done pulse after the last set.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush_req) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + SET_W'(1);
        if (flush_cnt_q == SET_W'(SETS-1)) begin
          state_d      = S_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, flush counter and done pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flush_cnt_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Valid bits: set by fills, cleared a set at a time by the flush walk.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          valid_q[s][w] <= 1'b0;
    end else begin
      if (fill)
        valid_q[wr_set][victim] <= 1'b1;
      if (state_q == S_FLUSH)
        for (int w = 0; w < WAYS; w++)
          valid_q[flush_cnt_q][w] <= 1'b0;
    end
  end

  // LRU ages register; reset puts each set in identity order.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

  // Tag and data arrays are gated by valids, so they carry no reset.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[wr_set][victim]  <= wr_tag;
      data_q[wr_set][victim] <= bus.wr_data;
    end
  end

  // Registered read results; misses return zero data and way 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_hit_q  <= '0;
      rd_data_q <= '0;
      rd_way_q  <= '0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        rd_hit_q[p]                     <= lk_hit[p];
        rd_data_q[p*LINE_W +: LINE_W]   <= lk_hit[p] ? data_q[rd_set[p]][lk_way[p]] : '0;
        rd_way_q[p*WAY_W +: WAY_W]      <= lk_hit[p] ? lk_way[p] : '0;
      end
    end
  end
endmodule
